// File: rtl/keyboard.sv
// -----------------------------------------------------------------------------
// keyboard -- PS/2 set-2 scan code decoder driving a ZX Spectrum 8x5 key matrix.
//
// Ports
//   clock        system clock; all state changes on the rising edge
//   reset        asynchronous, active-low; clears all state while low
//   ce           clock enable; state advances only on edges with ce=1
//   kstb         one-ce-cycle strobe from the PS/2 receiver; code valid with it
//   code[7:0]    PS/2 set-2 scan code byte
//   addr[7:0]    ZX row select (CPU A15..A8); a low bit r selects row r
//   keys[4:0]    ZX column data, active-low, combinational from addr
//   nmi          high while F5 (03) is held
//   boot         high while F12 (07) is held
//
// Internally a held key is a 1 in 'matrix'. Keys that stand for two ZX keys
// (Backspace, cursor arrows) keep private 'combo' bits that are ORed into the
// matrix only at the read port, so a combo release never cancels a physically
// held CapsShift or digit.
// -----------------------------------------------------------------------------
module keyboard (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       kstb,
  input  logic [7:0] code,
  input  logic [7:0] addr,
  output logic [4:0] keys,
  output logic       nmi,
  output logic       boot
);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;

  // Combo bit assignment.
  localparam int CB_BKSP  = 0;  // Backspace   -> CapsShift + 0
  localparam int CB_LEFT  = 1;  // E0 6B       -> CapsShift + 5
  localparam int CB_DOWN  = 2;  // E0 72       -> CapsShift + 6
  localparam int CB_UP    = 3;  // E0 75       -> CapsShift + 7
  localparam int CB_RIGHT = 4;  // E0 74       -> CapsShift + 8

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  // Non-extended scan code to matrix position.
  function automatic key_pos_t map_code(input logic [7:0] c);
    key_pos_t p;
    p = '0;
    p.hit = 1'b1;
    case (c)
      8'h12: begin p.row = 3'd0; p.col = 3'd0; end  // LShift (CapsShift)
      8'h1A: begin p.row = 3'd0; p.col = 3'd1; end  // Z
      8'h22: begin p.row = 3'd0; p.col = 3'd2; end  // X
      8'h21: begin p.row = 3'd0; p.col = 3'd3; end  // C
      8'h2A: begin p.row = 3'd0; p.col = 3'd4; end  // V
      8'h1C: begin p.row = 3'd1; p.col = 3'd0; end  // A
      8'h1B: begin p.row = 3'd1; p.col = 3'd1; end  // S
      8'h23: begin p.row = 3'd1; p.col = 3'd2; end  // D
      8'h2B: begin p.row = 3'd1; p.col = 3'd3; end  // F
      8'h34: begin p.row = 3'd1; p.col = 3'd4; end  // G
      8'h15: begin p.row = 3'd2; p.col = 3'd0; end  // Q
      8'h1D: begin p.row = 3'd2; p.col = 3'd1; end  // W
      8'h24: begin p.row = 3'd2; p.col = 3'd2; end  // E
      8'h2D: begin p.row = 3'd2; p.col = 3'd3; end  // R
      8'h2C: begin p.row = 3'd2; p.col = 3'd4; end  // T
      8'h16: begin p.row = 3'd3; p.col = 3'd0; end  // 1
      8'h1E: begin p.row = 3'd3; p.col = 3'd1; end  // 2
      8'h26: begin p.row = 3'd3; p.col = 3'd2; end  // 3
      8'h25: begin p.row = 3'd3; p.col = 3'd3; end  // 4
      8'h2E: begin p.row = 3'd3; p.col = 3'd4; end  // 5
      8'h45: begin p.row = 3'd4; p.col = 3'd0; end  // 0
      8'h46: begin p.row = 3'd4; p.col = 3'd1; end  // 9
      8'h3E: begin p.row = 3'd4; p.col = 3'd2; end  // 8
      8'h3D: begin p.row = 3'd4; p.col = 3'd3; end  // 7
      8'h36: begin p.row = 3'd4; p.col = 3'd4; end  // 6
      8'h4D: begin p.row = 3'd5; p.col = 3'd0; end  // P
      8'h44: begin p.row = 3'd5; p.col = 3'd1; end  // O
      8'h43: begin p.row = 3'd5; p.col = 3'd2; end  // I
      8'h3C: begin p.row = 3'd5; p.col = 3'd3; end  // U
      8'h35: begin p.row = 3'd5; p.col = 3'd4; end  // Y
      8'h5A: begin p.row = 3'd6; p.col = 3'd0; end  // Enter
      8'h4B: begin p.row = 3'd6; p.col = 3'd1; end  // L
      8'h42: begin p.row = 3'd6; p.col = 3'd2; end  // K
      8'h3B: begin p.row = 3'd6; p.col = 3'd3; end  // J
      8'h33: begin p.row = 3'd6; p.col = 3'd4; end  // H
      8'h29: begin p.row = 3'd7; p.col = 3'd0; end  // Space
      8'h59: begin p.row = 3'd7; p.col = 3'd1; end  // RShift -> SymShift
      8'h14: begin p.row = 3'd7; p.col = 3'd1; end  // LCtrl  -> SymShift
      8'h3A: begin p.row = 3'd7; p.col = 3'd2; end  // M
      8'h31: begin p.row = 3'd7; p.col = 3'd3; end  // N
      8'h32: begin p.row = 3'd7; p.col = 3'd4; end  // B
      default: p.hit = 1'b0;
    endcase
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0][4:0] matrix, matrix_n;
  logic [4:0]      combo,  combo_n;
  logic            ext,    ext_n;
  logic            brk,    brk_n;
  logic [2:0]      skip,   skip_n;
  logic            nmi_n,  boot_n;

  // NOTE: the key matrix is state the CPU reads directly, so it is reset with
  // everything else; leaving it unreset would show phantom keys after power-up.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the next-state logic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      matrix <= '0;
      combo  <= '0;
      ext    <= 1'b0;
      brk    <= 1'b0;
      skip   <= 3'd0;
      nmi    <= 1'b0;
      boot   <= 1'b0;
    end else begin
      matrix <= matrix_n;
      combo  <= combo_n;
      ext    <= ext_n;
      brk    <= brk_n;
      skip   <= skip_n;
      nmi    <= nmi_n;
      boot   <= boot_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------------
  key_pos_t pos;

  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    matrix_n = matrix;
    combo_n  = combo;
    ext_n    = ext;
    brk_n    = brk;
    skip_n   = skip;
    nmi_n    = nmi;
    boot_n   = boot;
    pos      = map_code(code);

    if (ce && kstb) begin
      if (skip != 3'd0) begin
        // Swallowing the remainder of the Pause sequence.
        skip_n = skip - 3'd1;
      end else if (code == CODE_PAUSE) begin
        skip_n = 3'd7;
      end else if (code == CODE_EXT) begin
        ext_n = 1'b1;
      end else if (code == CODE_BRK) begin
        brk_n = 1'b1;
      end else begin
        // Key event: mapped or not, the prefix flags are consumed here.
        ext_n = 1'b0;
        brk_n = 1'b0;
        if (!ext) begin
          if (pos.hit) matrix_n[pos.row][pos.col] = ~brk;
          case (code)
            8'h66:   combo_n[CB_BKSP] = ~brk;
            8'h03:   nmi_n            = ~brk;
            8'h07:   boot_n           = ~brk;
            default: ;
          endcase
        end else begin
          case (code)
            8'h6B:   combo_n[CB_LEFT]  = ~brk;
            8'h72:   combo_n[CB_DOWN]  = ~brk;
            8'h75:   combo_n[CB_UP]    = ~brk;
            8'h74:   combo_n[CB_RIGHT] = ~brk;
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: fold combo bits into the matrix, then wired-AND selected rows.
  // ---------------------------------------------------------------------------
  logic [7:0][4:0] eff;
  logic [4:0]      pressed;

  always_comb begin
    eff       = matrix;
    eff[0][0] = matrix[0][0] | (|combo);          // CapsShift
    eff[4][0] = matrix[4][0] | combo[CB_BKSP];    // 0
    eff[3][4] = matrix[3][4] | combo[CB_LEFT];    // 5
    eff[4][4] = matrix[4][4] | combo[CB_DOWN];    // 6
    eff[4][3] = matrix[4][3] | combo[CB_UP];      // 7
    eff[4][2] = matrix[4][2] | combo[CB_RIGHT];   // 8

    pressed = '0;
    for (int r = 0; r < 8; r++) begin
      if (!addr[r]) pressed = pressed | eff[r];
    end
    keys = ~pressed;
  end

endmodule

// File: tb/tb_keyboard.sv
// -----------------------------------------------------------------------------
// tb_keyboard -- directed bench for the PS/2 to ZX matrix decoder.
// Expected values are hand-derived from the key table; outputs are sampled
// 1 time unit after the rising edge that consumed the strobe.
// -----------------------------------------------------------------------------
module tb_keyboard;

  logic       clock;
  logic       reset;
  logic       ce;
  logic       kstb;
  logic [7:0] code;
  logic [7:0] addr;
  logic [4:0] keys;
  logic       nmi;
  logic       boot;

  int errors = 0;
  int checks = 0;

  keyboard dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .kstb  (kstb),
    .code  (code),
    .addr  (addr),
    .keys  (keys),
    .nmi   (nmi),
    .boot  (boot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog: the directed sequence is short; anything this long is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_keys(input string tag, input logic [7:0] a, input logic [4:0] exp);
    addr = a;
    #1;
    check(tag, {3'b000, keys}, {3'b000, exp});
  endtask

  // One strobe consumed on the next rising edge; returns 1 unit after it.
  task automatic strobe_ce(input logic [7:0] c, input logic en);
    @(negedge clock);
    kstb = 1'b1;
    code = c;
    ce   = en;
    @(posedge clock);
    #1;
    kstb = 1'b0;
    ce   = 1'b1;
    code = 8'h00;
  endtask

  task automatic strobe(input logic [7:0] c);
    strobe_ce(c, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    #2;
    check("reset_keys_00", {3'b000, keys}, 8'h1F);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    ce    = 1'b1;
    kstb  = 1'b0;
    code  = 8'h00;
    addr  = 8'hFF;

    // Reset state
    #12;
    check_keys("rst_keys_FF", 8'hFF, 5'h1F);
    check_keys("rst_keys_00", 8'h00, 5'h1F);
    check("rst_nmi",  {7'b0, nmi},  8'h00);
    check("rst_boot", {7'b0, boot}, 8'h00);
    @(negedge clock);
    reset = 1'b1;

    // Plain make/break of Z
    strobe(8'h1A);
    check_keys("z_make", 8'hFE, 5'h1D);
    strobe(8'hF0); strobe(8'h1A);
    check_keys("z_break", 8'hFE, 5'h1F);

    // Strobe with ce=0 is ignored
    strobe_ce(8'h1A, 1'b0);
    check_keys("ce_low_ignored", 8'hFE, 5'h1F);

    // Cursor up: CapsShift + 7
    strobe(8'hE0); strobe(8'h75);
    check_keys("up_row0", 8'hFE, 5'h1E);
    check_keys("up_row4", 8'hEF, 5'h17);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h75);
    check_keys("up_rel_row0", 8'hFE, 5'h1F);
    check_keys("up_rel_row4", 8'hEF, 5'h1F);

    // LShift held across a left-arrow combo
    strobe(8'h12);
    check_keys("lshift_make", 8'hFE, 5'h1E);
    strobe(8'hE0); strobe(8'h6B);
    check_keys("left_row0", 8'hFE, 5'h1E);
    check_keys("left_row3", 8'hF7, 5'h0F);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h6B);
    check_keys("left_rel_row0", 8'hFE, 5'h1E);
    check_keys("left_rel_row3", 8'hF7, 5'h1F);
    strobe(8'hF0); strobe(8'h12);
    check_keys("lshift_break", 8'hFE, 5'h1F);

    // Physical 0 survives a Backspace release; down arrow -> 6
    strobe(8'h45); strobe(8'h66);
    check_keys("bksp_row0", 8'hFE, 5'h1E);
    strobe(8'hF0); strobe(8'h66);
    check_keys("bksp_rel_row4", 8'hEF, 5'h1E);
    check_keys("bksp_rel_row0", 8'hFE, 5'h1F);
    strobe(8'hF0); strobe(8'h45);
    strobe(8'hE0); strobe(8'h72);
    check_keys("down_row4", 8'hEF, 5'h0F);
    strobe(8'hE0); strobe(8'h74);
    check_keys("down_right_row4", 8'hEF, 5'h0B);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h72);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h74);
    check_keys("down_right_rel", 8'hEE, 5'h1F);

    // Pause sequence swallowed, then A
    strobe(8'hE1); strobe(8'h14); strobe(8'h77); strobe(8'hE1);
    strobe(8'hF0); strobe(8'h14); strobe(8'hF0); strobe(8'h77);
    check_keys("pause_all_rows", 8'h00, 5'h1F);
    strobe(8'h1C);
    check_keys("pause_then_a", 8'hFD, 5'h1E);
    strobe(8'hF0); strobe(8'h1C);
    check_keys("a_break", 8'hFD, 5'h1F);

    // Multi-row wired-AND, boot and nmi
    strobe(8'h16); strobe(8'h45);
    check_keys("rows34_and", 8'hE7, 5'h1E);
    strobe(8'h07);
    check("boot_make", {7'b0, boot}, 8'h01);
    strobe(8'hF0); strobe(8'h07);
    check("boot_break", {7'b0, boot}, 8'h00);
    strobe(8'h03);
    check("nmi_make", {7'b0, nmi}, 8'h01);
    strobe(8'hF0); strobe(8'h03);
    check("nmi_break", {7'b0, nmi}, 8'h00);
    strobe(8'hF0); strobe(8'h16); strobe(8'hF0); strobe(8'h45);
    check_keys("rows34_rel", 8'hE7, 5'h1F);

    // SymShift from two sources is a single bit
    strobe(8'h59);
    check_keys("symshift_rshift", 8'h7F, 5'h1D);
    strobe(8'h14);
    strobe(8'hF0); strobe(8'h14);
    check_keys("symshift_cleared", 8'h7F, 5'h1F);

    // Typematic repeat and stray break
    strobe(8'h1A); strobe(8'h1A); strobe(8'h1A);
    check_keys("typematic_held", 8'hFE, 5'h1D);
    strobe(8'hF0); strobe(8'h1A);
    check_keys("typematic_rel", 8'hFE, 5'h1F);
    strobe(8'hF0); strobe(8'h22);
    check_keys("stray_break", 8'hFE, 5'h1F);

    // Unmapped byte clears a pending break; ignored extended code
    strobe(8'hF0); strobe(8'hAA); strobe(8'h1A);
    check_keys("unmapped_clears_brk", 8'hFE, 5'h1D);
    strobe(8'hF0); strobe(8'h1A);
    strobe(8'hE0); strobe(8'h12);
    check_keys("ext_unmapped", 8'hFE, 5'h1F);

    // Reset discards a pending E0
    strobe(8'hE0);
    pulse_reset();
    strobe(8'h75);
    check_keys("reset_drops_ext", 8'hEF, 5'h1F);

    // Reset discards an in-progress Pause skip
    strobe(8'hE1); strobe(8'h14);
    pulse_reset();
    strobe(8'h1C);
    check_keys("reset_drops_skip", 8'hFD, 5'h1E);

    // Reset clears held keys and boot
    strobe(8'h07);
    pulse_reset();
    check("reset_boot", {7'b0, boot}, 8'h00);
    check_keys("reset_clears_a", 8'hFD, 5'h1F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
